// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared register-file geometry, arbiter state encoding and starvation default.
`default_nettype none

package rf_wb_arbiter_pkg;

  localparam int RF_DATA_WIDTH     = 32;
  localparam int RF_REG_DEPTH      = 32;
  localparam int RF_ADDR_WIDTH     = 5;
  localparam int RF_STARVE_LIMIT   = 4;

  typedef enum logic {
    PRIO_LSU = 1'b0,
    PRIO_ALU = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bit per architectural register; set on issue, clear on writeback.
`default_nettype none

module rf_scoreboard #(
  parameter int REG_DEPTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      set_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] set_idx_i,
  input  logic                      clr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] clr_idx_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o
);

  logic [REG_DEPTH-1:0] busy_q, busy_d;

  // A same-edge set beats a clear: the newer producer is still in flight.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < REG_DEPTH; i++) begin
      if (set_en_i && (set_idx_i == REG_ADDR_WIDTH'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_en_i && (clr_idx_i == REG_ADDR_WIDTH'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU and LSU writeback,
// with starvation-bounded LSU priority and a busy-register scoreboard.
`default_nettype none

module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = RF_DATA_WIDTH,
  parameter int REG_DEPTH      = RF_REG_DEPTH,
  parameter int REG_ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int STARVE_LIMIT   = RF_STARVE_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e                state_q, state_d;
  logic [CNT_W-1:0]          starve_q, starve_d;
  logic                      alu_gnt, lsu_gnt, any_gnt;
  logic [REG_ADDR_WIDTH-1:0] gnt_rd;
  logic [DATA_WIDTH-1:0]     gnt_data;
  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;

  always_comb begin
    alu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;
    state_d  = state_q;
    starve_d = '0;

    if (state_q == PRIO_ALU) begin
      alu_gnt = alu_valid;
      lsu_gnt = lsu_valid && !alu_valid;
    end else begin
      lsu_gnt = lsu_valid;
      alu_gnt = alu_valid && !lsu_valid;
    end

    // Counter saturates at the limit; it can never exceed it because the ALU then wins.
    if (alu_valid && !alu_gnt) begin
      starve_d = (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end

    if (state_q == PRIO_LSU) begin
      if (alu_valid && !alu_gnt && ((32'(starve_q) + 32'd1) >= 32'(STARVE_LIMIT))) begin
        state_d = PRIO_ALU;
      end
    end else if (alu_gnt) begin
      state_d = PRIO_LSU;
    end
  end

  assign any_gnt  = alu_gnt || lsu_gnt;
  assign gnt_rd   = alu_gnt ? alu_rd : lsu_rd;
  assign gnt_data = alu_gnt ? alu_data : lsu_data;

  always_comb begin
    rf_we_d    = any_gnt && (gnt_rd != '0);
    rf_waddr_d = any_gnt ? gnt_rd : rf_waddr_q;
    rf_wdata_d = any_gnt ? gnt_data : rf_wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRIO_LSU;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign alu_ready = rst_n && alu_gnt;
  assign lsu_ready = rst_n && lsu_gnt;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

  rf_scoreboard #(
    .REG_DEPTH      (REG_DEPTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (iss_valid),
    .set_idx_i  (iss_rd),
    .clr_en_i   (rf_we_q),
    .clr_idx_i  (rf_waddr_q),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, iss_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
  logic [31:0] alu_data, lsu_data;
  logic        rs1_busy, rs2_busy, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_busy [32];
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_lost;
  bit          m_alu_owed;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    m_lost = 0; m_alu_owed = 1'b0;
  endtask

  function automatic void model_grant(output bit ga, output bit gl);
    ga = alu_valid && (m_alu_owed || !lsu_valid);
    gl = lsu_valid && !ga;
  endfunction

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
  endtask

  // Compare everything observable against the model, away from the clock edge.
  task automatic sample();
    bit ga, gl;
    @(negedge clk);
    model_grant(ga, gl);
    check("alu_ready", alu_ready, rst_n && ga);
    check("lsu_ready", lsu_ready, rst_n && gl);
    check("rf_we", rf_we, m_we);
    if (m_we) begin
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
    end
    check("rs1_busy", rs1_busy, m_busy[rs1_addr]);
    check("rs2_busy", rs2_busy, m_busy[rs2_addr]);
  endtask

  task automatic advance();
    bit ga, gl;
    logic [4:0] rd;
    model_grant(ga, gl);
    if (rst_n) begin
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      rd   = ga ? alu_rd : lsu_rd;
      m_we = (ga || gl) && (rd != 0);
      if (ga || gl) begin
        m_waddr = rd;
        m_wdata = ga ? alu_data : lsu_data;
      end
      if (m_alu_owed) begin
        if (ga) m_alu_owed = 1'b0;
        m_lost = 0;
      end else begin
        m_lost = (alu_valid && !ga) ? m_lost + 1 : 0;
        if (m_lost >= LIMIT) m_alu_owed = 1'b1;
      end
      if (!alu_valid || ga) m_lost = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; idle();
    alu_rd = 0; lsu_rd = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    alu_data = 0; lsu_data = 0;
    model_reset();
    alu_valid = 1; lsu_valid = 1;
    sample();
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1; idle();

    // Single ALU writeback
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    sample(); check("t1_ready", alu_ready, 1);
    advance(); idle();
    sample();
    check("t1_we", rf_we, 1); check("t1_addr", rf_waddr, 5); check("t1_data", rf_wdata, 32'hDEADBEEF);
    advance();
    sample(); check("t1_we_off", rf_we, 0);
    advance();

    // Starvation: LSU wins 4 cycles, then ALU once, then LSU again
    alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2;
    for (int c = 0; c < 6; c++) begin
      alu_data = 32'(c); lsu_data = 32'(100 + c);
      sample();
      check("t2_alu", alu_ready, (c == 4) ? 1 : 0);
      check("t2_lsu", lsu_ready, (c == 4) ? 0 : 1);
      check("t2_excl", alu_ready & lsu_ready, 0);
      advance();
    end
    idle(); sample(); advance(); sample(); advance();

    // Issue then LSU writeback to x7
    iss_valid = 1; iss_rd = 7; rs1_addr = 7;
    sample(); advance(); idle();
    sample(); check("t3_busy_set", rs1_busy, 1);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    advance(); idle();
    sample(); check("t3_we", rf_we, 1); check("t3_busy_wb", rs1_busy, 1);
    advance();
    sample(); check("t3_busy_clr", rs1_busy, 0);

    // Same-edge set and clear on x9
    iss_valid = 1; iss_rd = 9; rs1_addr = 9;
    advance(); idle();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    sample(); advance(); idle();
    iss_valid = 1; iss_rd = 9;
    sample(); check("t4_we9", rf_waddr, 9);
    advance(); idle();
    sample(); check("t4_busy_kept", rs1_busy, 1);
    advance();

    // Writeback to x0
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; rs1_addr = 0;
    sample(); check("t5_ready", alu_ready, 1);
    advance(); idle();
    sample(); check("t5_we", rf_we, 0); check("t5_busy0", rs1_busy, 0);
    advance();

    // Reset mid-stream with busy[3] set and a write pending
    iss_valid = 1; iss_rd = 3; rs1_addr = 3;
    sample(); advance();
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44; iss_valid = 0;
    sample(); check("t6_busy3", rs1_busy, 1);
    advance();
    #2 rst_n = 0;
    #1;
    check("t6_we", rf_we, 0);
    check("t6_busy", rs1_busy, 0);
    check("t6_ready", alu_ready, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; alu_valid = 1; lsu_valid = 1; alu_rd = 6; lsu_rd = 8;
    sample(); check("t6_prio_lsu", lsu_ready, 1);
    advance(); idle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      alu_valid = ($urandom_range(0, 3) != 0);
      lsu_valid = ($urandom_range(0, 2) != 0);
      iss_valid = $urandom_range(0, 1);
      alu_rd    = 5'($urandom_range(0, 10));
      lsu_rd    = 5'($urandom_range(0, 10));
      iss_rd    = 5'($urandom_range(0, 10));
      rs1_addr  = 5'($urandom_range(0, 10));
      rs2_addr  = 5'($urandom);
      alu_data  = $urandom;
      lsu_data  = $urandom;
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
